// File: rtl/vjtag_pkg.sv
// Shared IR encodings and data-register widths for the virtual-JTAG register bridge.
package vjtag_pkg;

  typedef enum logic [1:0] {
    IR_BYPASS = 2'd0,
    IR_ADDR   = 2'd1,
    IR_DATA   = 2'd2,
    IR_STATUS = 2'd3
  } ir_e;

  localparam int W_BYPASS = 1;
  localparam int W_ADDR   = 8;
  localparam int W_DATA   = 8;
  localparam int W_STATUS = 16;

  localparam logic [7:0] WR_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/vjtag_reg_bridge_if.sv
// Hub-side signal bundle of the register bridge; master drives the JTAG side, slave is the bridge.
interface vjtag_reg_bridge_if (
  input logic tck
);
  logic        tdi;
  logic        tdo;
  logic [1:0]  ir_in;
  logic        virtual_state_cdr;
  logic        virtual_state_sdr;
  logic        virtual_state_udr;
  logic [3:0]  status_in;
  logic [31:0] reg_out;
  logic        wr_strobe;
  logic [1:0]  wr_addr;

  modport master (
    input  tck, tdo, reg_out, wr_strobe, wr_addr,
    output tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr, status_in
  );

  modport slave (
    input  tck, tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr, status_in,
    output tdo, reg_out, wr_strobe, wr_addr
  );
endinterface

// File: rtl/vjtag_dr_shift.sv
// One LSB-first JTAG data register: parallel capture of `load`, serial shift-in of tdi at the MSB.
module vjtag_dr_shift #(
  parameter int W = 8
) (
  input  logic         tck,
  input  logic         reset,
  input  logic         capture,
  input  logic         shift,
  input  logic         tdi,
  input  logic [W-1:0] load,
  output logic [W-1:0] dr
);

  // Widened by one so the shift expression also holds for a 1-bit register.
  logic [W:0] ext;
  assign ext = {tdi, dr};

  always_ff @(posedge tck) begin
    if (reset)        dr <= '0;
    else if (capture) dr <= load;
    else if (shift)   dr <= ext[W:1];
  end

endmodule

// File: rtl/vjtag_reg_bridge.sv
// Virtual-JTAG bridge: ADDR/DATA/STATUS/BYPASS data registers driving a small bank of 8-bit registers.
module vjtag_reg_bridge
  import vjtag_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic               tck,
  input  logic               reset,
  input  logic               tdi,
  output logic               tdo,
  input  logic [1:0]         ir_in,
  input  logic               virtual_state_cdr,
  input  logic               virtual_state_sdr,
  input  logic               virtual_state_udr,
  input  logic [3:0]         status_in,
  output logic [8*NREGS-1:0] reg_out,
  output logic               wr_strobe,
  output logic [1:0]         wr_addr
);

  logic [1:0]            addr;
  logic                  autoinc;
  logic [7:0]            wr_count;
  logic [NREGS-1:0][7:0] regs;

  logic [W_BYPASS-1:0] dr_byp;
  logic [W_ADDR-1:0]   dr_addr;
  logic [W_DATA-1:0]   dr_data;
  logic [W_STATUS-1:0] dr_stat;

  // UDR outranks CDR, which outranks SDR.
  logic do_cdr, do_sdr;
  assign do_cdr = virtual_state_cdr & ~virtual_state_udr;
  assign do_sdr = virtual_state_sdr & ~virtual_state_cdr & ~virtual_state_udr;

  logic sel_byp, sel_addr, sel_data, sel_stat;
  assign sel_byp  = (ir_in == IR_BYPASS);
  assign sel_addr = (ir_in == IR_ADDR);
  assign sel_data = (ir_in == IR_DATA);
  assign sel_stat = (ir_in == IR_STATUS);

  vjtag_dr_shift #(.W(W_BYPASS)) u_dr_byp (
    .tck     (tck),
    .reset   (reset),
    .capture (do_cdr & sel_byp),
    .shift   (do_sdr & sel_byp),
    .tdi     (tdi),
    .load    (1'b0),
    .dr      (dr_byp)
  );

  vjtag_dr_shift #(.W(W_ADDR)) u_dr_addr (
    .tck     (tck),
    .reset   (reset),
    .capture (do_cdr & sel_addr),
    .shift   (do_sdr & sel_addr),
    .tdi     (tdi),
    .load    ({autoinc, 5'b0, addr}),
    .dr      (dr_addr)
  );

  vjtag_dr_shift #(.W(W_DATA)) u_dr_data (
    .tck     (tck),
    .reset   (reset),
    .capture (do_cdr & sel_data),
    .shift   (do_sdr & sel_data),
    .tdi     (tdi),
    .load    (regs[addr]),
    .dr      (dr_data)
  );

  vjtag_dr_shift #(.W(W_STATUS)) u_dr_stat (
    .tck     (tck),
    .reset   (reset),
    .capture (do_cdr & sel_stat),
    .shift   (do_sdr & sel_stat),
    .tdi     (tdi),
    .load    ({wr_count, status_in, autoinc, 1'b0, addr}),
    .dr      (dr_stat)
  );

  // Only the LSB of STATUS leaves the block; the ADDR DR spare bits are never decoded.
  logic unused_dr_bits;
  assign unused_dr_bits = ^{dr_addr[6:2], dr_stat[W_STATUS-1:1]};

  always_comb begin
    tdo = 1'b0;
    case (ir_in)
      IR_BYPASS: tdo = dr_byp[0];
      IR_ADDR:   tdo = dr_addr[0];
      IR_DATA:   tdo = dr_data[0];
      IR_STATUS: tdo = dr_stat[0];
      default:   tdo = 1'b0;
    endcase
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      addr      <= '0;
      autoinc   <= 1'b0;
      wr_count  <= '0;
      regs      <= '0;
      wr_addr   <= '0;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (virtual_state_udr) begin
        case (ir_in)
          IR_ADDR: begin
            addr    <= dr_addr[1:0];
            autoinc <= dr_addr[7];
          end
          IR_DATA: begin
            regs[addr] <= dr_data;
            wr_strobe  <= 1'b1;
            wr_addr    <= addr;
            if (wr_count != WR_COUNT_MAX) wr_count <= wr_count + 8'd1;
            if (autoinc) addr <= addr + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign reg_out = regs;

endmodule
